// File: rtl/lsu_mem_ctrl_if.sv
// Bundles the request/response handshake and the single-port RAM bus of the load/store sequencer.
// The slave modport is the controller; the master modport is the MEM stage plus the RAM.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              rsp_valid;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wd;
  logic [63:0]       mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wd
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV64I load/store sequencer in front of a 64-bit single-port synchronous RAM.
// Sub-doubleword stores use read-modify-write; misaligned/illegal requests never touch the RAM.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 64,
  parameter int IDX_HI = 12
) (
  input logic          clk,
  input logic          rst_n,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_WAIT  = 2'd1,
    ST_MERGE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic [31:0]       r_wdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [63:0]       r_rdata;

  logic              w_ready;
  logic              w_accept;
  logic              w_illegal;
  logic              w_misal;
  logic              w_err;
  logic              w_is_sd;
  logic              w_mem_we;
  logic [63:0]       w_mem_wd;
  logic [ADDR_W-1:0] w_addr_src;

  function automatic logic [63:0] extract_lane(input logic [63:0] rd, input logic [2:0] f3,
                                               input logic [2:0] lane);
    logic [63:0] sh;
    sh = rd >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{56{sh[7]}},  sh[7:0]};
      3'b001:  return {{48{sh[15]}}, sh[15:0]};
      3'b010:  return {{32{sh[31]}}, sh[31:0]};
      3'b100:  return {56'd0, sh[7:0]};
      3'b101:  return {48'd0, sh[15:0]};
      3'b110:  return {32'd0, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [63:0] merge_lane(input logic [63:0] old, input logic [31:0] wd,
                                             input logic [1:0] sz, input logic [2:0] lane);
    logic [63:0] mask;
    logic [63:0] data;
    case (sz)
      2'b00:   mask = 64'h0000_0000_0000_00FF;
      2'b01:   mask = 64'h0000_0000_0000_FFFF;
      default: mask = 64'h0000_0000_FFFF_FFFF;
    endcase
    mask = mask << {lane, 3'b000};
    data = {32'd0, wd} << {lane, 3'b000};
    return (old & ~mask) | (data & mask);
  endfunction

  assign w_ready  = (r_state == IDLE) && rst_n;
  assign w_accept = bus.req_valid && w_ready;
  assign w_is_sd  = bus.req_we && (bus.req_funct3 == 3'b011);

  assign w_illegal = bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
  always_comb begin
    w_misal = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   w_misal = bus.req_addr[0];
      2'b10:   w_misal = |bus.req_addr[1:0];
      2'b11:   w_misal = |bus.req_addr[2:0];
      default: w_misal = 1'b0;
    endcase
  end
  assign w_err = w_illegal || w_misal;

  // Alias bits above the RAM index are passed through untouched.
  assign w_addr_src   = (r_state == IDLE) ? bus.req_addr : r_addr;
  assign bus.mem_addr = {w_addr_src[ADDR_W-1:IDX_HI+1], w_addr_src[IDX_HI:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_mem_wd    = 64'd0;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_err) begin
          if (w_is_sd) begin
            w_mem_we = 1'b1;
            w_mem_wd = bus.req_wdata;
          end else if (bus.req_we) begin
            w_state_nxt = ST_MERGE;
          end else begin
            w_state_nxt = LD_WAIT;
          end
        end
      end
      LD_WAIT: w_state_nxt = IDLE;
      ST_MERGE: begin
        w_mem_we    = 1'b1;
        w_mem_wd    = merge_lane(bus.mem_rd, r_wdata, r_funct3[1:0], r_addr[2:0]);
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset held low must silence the RAM even mid-merge.
  assign bus.mem_we    = w_mem_we && rst_n;
  assign bus.mem_wd    = rst_n ? w_mem_wd : 64'd0;
  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_funct3    <= 3'd0;
      r_wdata     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= 64'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= (w_accept && (w_err || w_is_sd)) || (r_state != IDLE);
      r_rsp_err   <= w_accept && w_err;
      if (w_accept) begin
        r_addr   <= bus.req_addr;
        r_funct3 <= bus.req_funct3;
        r_wdata  <= bus.req_wdata[31:0];
      end
      if (r_state == LD_WAIT) begin
        r_rdata <= extract_lane(bus.mem_rd, r_funct3, r_addr[2:0]);
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed plus randomized bench for lsu_mem_ctrl; a byte-array memory model predicts every result.
module tb_lsu_mem_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  logic [63:0] ram [1024];
  logic [7:0]  mbytes [8192];
  logic [63:0] exp_rdata;

  lsu_mem_ctrl_if #(.ADDR_W(64)) bus ();

  lsu_mem_ctrl #(.ADDR_W(64), .IDX_HI(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, synchronous read-first.
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[12:3]] <= bus.mem_wd;
    bus.mem_rd <= ram[bus.mem_addr[12:3]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [63:0] a);
    int n;
    if (we && f3 > 3'd3) return 1'b1;
    if (!we && f3 == 3'd7) return 1'b1;
    n = 1 << f3[1:0];
    return (a % 64'(n)) != 0;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = 64'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mbytes[int'(a[12:0]) + i];
    if (!f3[2] && n < 8 && v[8*n-1]) begin
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    int n;
    n = 1 << f3[1:0];
    for (int i = 0; i < n; i++) mbytes[int'(a[12:0]) + i] = wd[8*i +: 8];
  endtask

  function automatic logic [63:0] model_word(input logic [63:0] a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mbytes[int'({a[12:3], 3'b000}) + i];
    return v;
  endfunction

  // Called at a negedge with the controller idle; returns at the negedge where rsp_valid shows.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd);
    bit err;
    bit sd;
    int n;
    err = model_err(we, f3, a);
    sd  = we && f3 == 3'd3 && !err;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    #1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("req_ready", 64'(bus.req_ready), 64'd1);
    chk("mem_we_accept", 64'(bus.mem_we), 64'(sd));
    if (sd) chk("mem_wd_sd", bus.mem_wd, wd);
    if (we && !err) model_store(f3, a, wd);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (!err && !sd) begin
      chk("rsp_early", 64'(bus.rsp_valid), 64'd0);
      if (we) begin
        chk("mem_we_merge", 64'(bus.mem_we), 64'd1);
        chk("mem_wd_merge", bus.mem_wd, model_word(a));
      end
      @(negedge clk);
    end
    chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("rsp_err", 64'(bus.rsp_err), 64'(err));
    if (!we && !err) exp_rdata = model_load(f3, a);
    chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rw;
    logic [2:0]  rf;
    logic        rwe;
    n_checks = 0;
    n_pass   = 0;
    exp_rdata = 64'd0;
    for (int i = 0; i < 1024; i++) ram[i] = 64'd0;
    for (int i = 0; i < 8192; i++) mbytes[i] = 8'd0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 64'd0;
    bus.req_wdata  = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b1, 3'b011, 64'h10, 64'h1122_3344_5566_7788);
    do_req(1'b0, 3'b011, 64'h10, 64'd0);
    chk("ld_0x10", bus.rsp_rdata, 64'h1122_3344_5566_7788);
    do_req(1'b1, 3'b000, 64'h13, 64'hAB);
    chk("sb_word", ram[2], 64'h1122_3344_AB66_7788);
    do_req(1'b0, 3'b000, 64'h13, 64'd0);
    chk("lb_0x13", bus.rsp_rdata, 64'hFFFF_FFFF_FFFF_FFAB);
    do_req(1'b0, 3'b100, 64'h13, 64'd0);
    chk("lbu_0x13", bus.rsp_rdata, 64'h0000_0000_0000_00AB);
    do_req(1'b1, 3'b001, 64'h16, 64'h8001);
    chk("sh_word", ram[2], 64'h8001_3344_AB66_7788);
    do_req(1'b0, 3'b001, 64'h16, 64'd0);
    chk("lh_0x16", bus.rsp_rdata, 64'hFFFF_FFFF_FFFF_8001);
    do_req(1'b0, 3'b110, 64'h14, 64'd0);
    chk("lwu_0x14", bus.rsp_rdata, 64'h0000_0000_8001_3344);

    do_req(1'b0, 3'b010, 64'h12, 64'd0);
    do_req(1'b1, 3'b011, 64'h0C, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("err_ram_08", ram[1], 64'd0);
    chk("err_ram_10", ram[2], 64'h8001_3344_AB66_7788);
    do_req(1'b1, 3'b100, 64'h10, 64'h55);
    do_req(1'b0, 3'b111, 64'h10, 64'd0);

    // Reset during the merge cycle of an SW.
    do_req(1'b1, 3'b011, 64'h28, 64'h0123_4567_89AB_CDEF);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 64'h28;
    bus.req_wdata  = 64'hCAFE_F00D;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_mid_we_before", 64'(bus.mem_we), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mid_wd", bus.mem_wd, 64'd0);
    exp_rdata = 64'd0;
    @(negedge clk);
    chk("rst_mid_rsp", 64'(bus.rsp_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_rsp2", 64'(bus.rsp_valid), 64'd0);
    do_req(1'b0, 3'b011, 64'h28, 64'd0);
    chk("rst_mid_ld", bus.rsp_rdata, 64'h0123_4567_89AB_CDEF);

    // SW then LW held back-to-back.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 64'h34;
    bus.req_wdata  = 64'h0000_0000_9ABC_DEF0;
    #1;
    chk("b2b_ready0", 64'(bus.req_ready), 64'd1);
    model_store(3'b010, 64'h34, 64'h9ABC_DEF0);
    @(negedge clk);
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    #1;
    chk("b2b_ready1", 64'(bus.req_ready), 64'd0);
    chk("b2b_merge_wd", bus.mem_wd, model_word(64'h34));
    @(negedge clk);
    #1;
    chk("b2b_ready2", 64'(bus.req_ready), 64'd1);
    chk("b2b_sw_rsp", 64'(bus.rsp_valid), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("b2b_lw_early", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    chk("b2b_lw_rsp", 64'(bus.rsp_valid), 64'd1);
    chk("b2b_lw_data", bus.rsp_rdata, 64'hFFFF_FFFF_9ABC_DEF0);
    exp_rdata = bus.rsp_rdata;
    @(negedge clk);
    chk("b2b_single_rsp", 64'(bus.rsp_valid), 64'd0);

    // Randomized traffic over 64 bytes with random alias bits.
    for (int k = 0; k < 60; k++) begin
      rwe = 1'($urandom_range(0, 1));
      rf  = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      ra[12:0] = 13'($urandom_range(0, 63));
      rw  = {$urandom, $urandom};
      do_req(rwe, rf, ra, rw);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
